vid_box_overlay: RTL and testbench

- Downstream vid_io stage placed directly after colour_change; consumes its o_vid_* stream.
- Tracks the active-pixel coordinate of every pixel from VDE and vsync.
- Draws a rectangular outline of programmable position, thickness-fixed border and colour over the processed video.
- Optionally blinks the outline at a frame-based rate; all other pixels and the sync signals pass through with matched latency.

---
 rtl/vid_box_overlay_if.sv | 14 +
 rtl/vid_box_overlay.sv | 143 ++++++++++++++
 tb/tb_vid_box_overlay.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_box_overlay_if.sv
`default_nettype none
// vid_box_overlay_if -- pixel stream bundle (data + hsync/vsync/VDE) between vid_io stages. Rev 1.0
interface vid_box_overlay_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] vid_data;
  logic                  vid_hsync;
  logic                  vid_vsync;
  logic                  vid_VDE;

  modport master (output vid_data, vid_hsync, vid_vsync, vid_VDE);
  modport slave  (input  vid_data, vid_hsync, vid_vsync, vid_VDE);
endinterface
`default_nettype wire

// File: rtl/vid_box_overlay.sv
`default_nettype none
// vid_box_overlay -- draws a frame-shadowed, optionally blinking rectangle outline
// over a vid_io stream with a fixed one-cycle latency. Rev 1.0
module vid_box_overlay #(
  parameter int DATA_WIDTH   = 24,
  parameter int CW           = 12,
  parameter int BORDER       = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  vid_box_overlay_if.slave           i_vid,
  vid_box_overlay_if.master          o_vid,
  input  wire logic [CW-1:0]         box_x0,
  input  wire logic [CW-1:0]         box_x1,
  input  wire logic [CW-1:0]         box_y0,
  input  wire logic [CW-1:0]         box_y1,
  input  wire logic [DATA_WIDTH-1:0] box_colour,
  input  wire logic                  box_en,
  input  wire logic                  blink_en,
  output logic [CW-1:0]              o_frame_cnt
);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0]        c_CNT_MAX    = '1;
  localparam logic [CW-1:0]        c_CNT_ONE    = CW'(1);
  localparam logic [BW-1:0]        c_BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [BW-1:0]        c_BLINK_ONE  = BW'(1);
  localparam logic signed [CW+1:0] c_BORDER     = (CW+2)'(BORDER);

  logic                  r_vsync_d, r_de_d;
  logic [CW-1:0]         r_x_cnt, r_y_cnt;
  logic [CW-1:0]         r_x0, r_x1, r_y0, r_y1;
  logic [DATA_WIDTH-1:0] r_colour;
  logic                  r_en, r_blink_en, r_visible;
  logic [BW-1:0]         r_blink_cnt;
  logic [CW-1:0]         r_frame_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_hs, r_vs, r_de;

  logic                  w_vs_rise, w_de_fall;
  logic signed [CW+1:0]  w_x, w_y, w_x0, w_x1, w_y0, w_y1;
  logic                  w_outer, w_inner, w_draw;

  assign w_vs_rise = i_vid.vid_vsync & ~r_vsync_d;
  assign w_de_fall = ~i_vid.vid_VDE & r_de_d;

  // Two extra bits keep x1-BORDER from wrapping when the box hugs coordinate 0.
  assign w_x  = $signed({2'b00, r_x_cnt});
  assign w_y  = $signed({2'b00, r_y_cnt});
  assign w_x0 = $signed({2'b00, r_x0});
  assign w_x1 = $signed({2'b00, r_x1});
  assign w_y0 = $signed({2'b00, r_y0});
  assign w_y1 = $signed({2'b00, r_y1});

  assign w_outer = (w_x >= w_x0) && (w_x <= w_x1) && (w_y >= w_y0) && (w_y <= w_y1);
  assign w_inner = (w_x >= w_x0 + c_BORDER) && (w_x <= w_x1 - c_BORDER) &&
                   (w_y >= w_y0 + c_BORDER) && (w_y <= w_y1 - c_BORDER);
  assign w_draw  = i_vid.vid_VDE & r_en & r_visible & w_outer & ~w_inner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_de_d    <= 1'b0;
      r_x_cnt   <= '0;
      r_y_cnt   <= '0;
    end else begin
      r_vsync_d <= i_vid.vid_vsync;
      r_de_d    <= i_vid.vid_VDE;
      if (!i_vid.vid_VDE)
        r_x_cnt <= '0;
      else if (r_x_cnt != c_CNT_MAX)
        r_x_cnt <= r_x_cnt + c_CNT_ONE;
      if (w_vs_rise)
        r_y_cnt <= '0;
      else if (w_de_fall && (r_y_cnt != c_CNT_MAX))
        r_y_cnt <= r_y_cnt + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_colour   <= '0;
      r_en       <= 1'b0;
      r_blink_en <= 1'b0;
    end else if (w_vs_rise) begin
      r_x0       <= box_x0;
      r_x1       <= box_x1;
      r_y0       <= box_y0;
      r_y1       <= box_y1;
      r_colour   <= box_colour;
      r_en       <= box_en;
      r_blink_en <= blink_en;
    end
  end

  // Blink state advances on the shadowed enable so a frame never changes phase mid-way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
    end else begin
      if (w_vs_rise)
        r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
      if (!r_blink_en) begin
        r_blink_cnt <= '0;
        r_visible   <= 1'b1;
      end else if (w_vs_rise) begin
        if (r_blink_cnt == c_BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_visible   <= ~r_visible;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_de   <= 1'b0;
    end else begin
      r_data <= w_draw ? r_colour : i_vid.vid_data;
      r_hs   <= i_vid.vid_hsync;
      r_vs   <= i_vid.vid_vsync;
      r_de   <= i_vid.vid_VDE;
    end
  end

  assign o_vid.vid_data  = r_data;
  assign o_vid.vid_hsync = r_hs;
  assign o_vid.vid_vsync = r_vs;
  assign o_vid.vid_VDE   = r_de;
  assign o_frame_cnt     = r_frame_cnt;
endmodule
`default_nettype wire

// File: tb/tb_vid_box_overlay.sv
`default_nettype none
// tb_vid_box_overlay -- scoreboard bench: two overlays (BORDER 1 and 2) fed one 8x6 stream. Rev 1.0
module tb_vid_box_overlay;
  localparam int DW   = 24;
  localparam int CW   = 12;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int LLEN = W + 4;
  localparam int FLEN = 4 + H * LLEN + 2;
  localparam int BF   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] box_x0 = '0, box_x1 = '0, box_y0 = '0, box_y1 = '0;
  logic [DW-1:0] box_colour = '0;
  logic          box_en = 1'b0, blink_en = 1'b0;
  logic [CW-1:0] fcnt1, fcnt2;

  always #5 clk = ~clk;

  vid_box_overlay_if #(.DATA_WIDTH(DW)) vin ();
  vid_box_overlay_if #(.DATA_WIDTH(DW)) vout1 ();
  vid_box_overlay_if #(.DATA_WIDTH(DW)) vout2 ();

  vid_box_overlay #(.DATA_WIDTH(DW), .CW(CW), .BORDER(1), .BLINK_FRAMES(BF)) dut1 (
    .clk(clk), .rst(rst), .i_vid(vin), .o_vid(vout1),
    .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
    .box_colour(box_colour), .box_en(box_en), .blink_en(blink_en), .o_frame_cnt(fcnt1));

  vid_box_overlay #(.DATA_WIDTH(DW), .CW(CW), .BORDER(2), .BLINK_FRAMES(BF)) dut2 (
    .clk(clk), .rst(rst), .i_vid(vin), .o_vid(vout2),
    .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
    .box_colour(box_colour), .box_en(box_en), .blink_en(blink_en), .o_frame_cnt(fcnt2));

  int total = 0;
  int bad   = 0;
  int p     = 0;
  int fr    = 0;
  int hits1 = 0;
  int hits2 = 0;

  // Reference model of the frame-latched box state.
  int            m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0;
  logic [DW-1:0] m_col = '0;
  bit            m_en = 1'b0, m_ben = 1'b0, m_vis = 1'b1;
  int            m_bcnt = 0, m_fcnt = 0;

  logic [77:0] obs;
  logic [77:0] sb[$];

  function automatic bit hit(int x, int y, int b);
    bit outer, inner;
    outer = (x >= m_x0) && (x <= m_x1) && (y >= m_y0) && (y <= m_y1);
    inner = (x >= m_x0 + b) && (x <= m_x1 - b) && (y >= m_y0 + b) && (y <= m_y1 - b);
    return outer && !inner;
  endfunction

  task automatic model_reset();
    m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_col = '0;
    m_en = 1'b0; m_ben = 1'b0; m_vis = 1'b1; m_bcnt = 0; m_fcnt = 0;
  endtask

  // Advance one clock: capture outputs for the previous input, drive the next frame position.
  task automatic step_next(output bit have, output logic [77:0] exp_v);
    int l, c, x, y;
    logic hs, vs, de;
    logic [DW-1:0] d, e1, e2;
    @(posedge clk);
    #1;
    obs = {vout1.vid_data, vout2.vid_data, vout1.vid_hsync, vout1.vid_vsync, vout1.vid_VDE,
           vout2.vid_hsync, vout2.vid_vsync, vout2.vid_VDE, fcnt1, fcnt2};
    if (vout1.vid_VDE && vout1.vid_data == box_colour) hits1++;
    if (vout2.vid_VDE && vout2.vid_data == box_colour) hits2++;
    vs = (p < 2); hs = 1'b0; de = 1'b0; x = 0; y = 0;
    if (p >= 4 && p < 4 + H * LLEN) begin
      l = (p - 4) / LLEN; c = (p - 4) % LLEN;
      de = (c < W); hs = (c == W + 1) || (c == W + 2);
      x = c; y = l;
    end
    d = {fr[7:0], p[7:0], 8'(p * 37)};
    if (p == 0) begin
      m_fcnt = (m_fcnt + 1) % (1 << CW);
      if (m_ben) begin
        if (m_bcnt == BF - 1) begin m_bcnt = 0; m_vis = !m_vis; end
        else m_bcnt++;
      end
      m_x0 = int'(box_x0); m_x1 = int'(box_x1); m_y0 = int'(box_y0); m_y1 = int'(box_y1);
      m_col = box_colour; m_en = box_en; m_ben = blink_en;
      if (!m_ben) begin m_vis = 1'b1; m_bcnt = 0; end
    end
    e1 = (de && m_en && m_vis && hit(x, y, 1)) ? m_col : d;
    e2 = (de && m_en && m_vis && hit(x, y, 2)) ? m_col : d;
    vin.vid_data = d; vin.vid_hsync = hs; vin.vid_vsync = vs; vin.vid_VDE = de;
    sb.push_back({e1, e2, hs, vs, de, hs, vs, de, CW'(m_fcnt), CW'(m_fcnt)});
    p = (p + 1) % FLEN;
    if (p == 0) fr++;
    have = (sb.size() > 1);
    exp_v = have ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    vin.vid_data = '0; vin.vid_hsync = 1'b0; vin.vid_vsync = 1'b0; vin.vid_VDE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({vout1.vid_data, vout1.vid_hsync, vout1.vid_vsync, vout1.vid_VDE, fcnt1} !== '0) begin
      bad++; $display("FAIL reset_dut1: got=%h exp=0", {vout1.vid_data, vout1.vid_VDE, fcnt1});
    end
    total++;
    if ({vout2.vid_data, vout2.vid_hsync, vout2.vid_vsync, vout2.vid_VDE, fcnt2} !== '0) begin
      bad++; $display("FAIL reset_dut2: got=%h exp=0", {vout2.vid_data, vout2.vid_VDE, fcnt2});
    end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_passthrough();
    bit hv; logic [77:0] ev;
    box_x0 = 1; box_x1 = 6; box_y0 = 1; box_y1 = 4; box_colour = 24'hFF0000;
    box_en = 1'b0; blink_en = 1'b0; hits1 = 0;
    repeat (FLEN) begin
      step_next(hv, ev);
      if (hv) begin
        total++;
        if (obs !== ev) begin bad++; $display("FAIL passthrough: got=%h exp=%h", obs, ev); end
      end
    end
    total++;
    if (hits1 !== 0) begin bad++; $display("FAIL passthrough_hits: got=%0d exp=0", hits1); end
  endtask

  task automatic test_outline();
    bit hv; logic [77:0] ev;
    box_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      hits1 = 0; hits2 = 0;
      repeat (FLEN) begin
        step_next(hv, ev);
        if (hv) begin
          total++;
          if (obs !== ev) begin bad++; $display("FAIL outline: got=%h exp=%h", obs, ev); end
        end
      end
    end
    total++;
    if (hits1 !== 16) begin bad++; $display("FAIL outline_hits_b1: got=%0d exp=16", hits1); end
    total++;
    if (hits2 !== 24) begin bad++; $display("FAIL outline_hits_b2: got=%0d exp=24", hits2); end
  endtask

  task automatic test_shadowing();
    bit hv; logic [77:0] ev;
    int exp_h[2];
    exp_h[0] = 16; exp_h[1] = 12;
    box_x0 = 1;
    for (int f = 0; f < 2; f++) begin
      hits1 = 0;
      for (int i = 0; i < FLEN; i++) begin
        step_next(hv, ev);
        if (f == 0 && i == 40) box_x0 = 3;
        if (hv) begin
          total++;
          if (obs !== ev) begin bad++; $display("FAIL shadowing: got=%h exp=%h", obs, ev); end
        end
      end
      total++;
      if (hits1 !== exp_h[f]) begin
        bad++; $display("FAIL shadowing_hits f%0d: got=%0d exp=%0d", f, hits1, exp_h[f]);
      end
    end
  endtask

  task automatic test_degenerate();
    bit hv; logic [77:0] ev;
    box_x0 = 5; box_x1 = 2; box_y0 = 1; box_y1 = 4; box_colour = 24'h00FF00;
    hits1 = 0;
    repeat (FLEN) begin
      step_next(hv, ev);
      if (hv) begin
        total++;
        if (obs !== ev) begin bad++; $display("FAIL degen_inverted: got=%h exp=%h", obs, ev); end
      end
    end
    total++;
    if (hits1 !== 0) begin bad++; $display("FAIL degen_inverted_hits: got=%0d exp=0", hits1); end
    box_x0 = 2; box_x1 = 4; box_y0 = 3; box_y1 = 3;
    hits1 = 0; hits2 = 0;
    repeat (FLEN) begin
      step_next(hv, ev);
      if (hv) begin
        total++;
        if (obs !== ev) begin bad++; $display("FAIL degen_thin: got=%h exp=%h", obs, ev); end
      end
    end
    total++;
    if (hits2 !== 3) begin bad++; $display("FAIL degen_thin_hits_b2: got=%0d exp=3", hits2); end
    total++;
    if (hits1 !== 3) begin bad++; $display("FAIL degen_thin_hits_b1: got=%0d exp=3", hits1); end
  endtask

  task automatic test_blink();
    bit hv; logic [77:0] ev;
    int exp_h[8];
    logic [CW-1:0] fc0;
    exp_h = '{16, 16, 0, 0, 16, 16, 16, 16};
    box_x0 = 1; box_x1 = 6; box_y0 = 1; box_y1 = 4; box_colour = 24'h0000FF;
    blink_en = 1'b1;
    fc0 = fcnt1;
    for (int f = 0; f < 8; f++) begin
      if (f == 6) begin
        total++;
        if (fcnt1 !== fc0 + CW'(6)) begin
          bad++; $display("FAIL blink_frame_cnt: got=%0d exp=%0d", fcnt1, fc0 + CW'(6));
        end
        blink_en = 1'b0;
      end
      hits1 = 0;
      repeat (FLEN) begin
        step_next(hv, ev);
        if (hv) begin
          total++;
          if (obs !== ev) begin bad++; $display("FAIL blink: got=%h exp=%h", obs, ev); end
        end
      end
      total++;
      if (hits1 !== exp_h[f]) begin
        bad++; $display("FAIL blink_hits f%0d: got=%0d exp=%0d", f, hits1, exp_h[f]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit hv; logic [77:0] ev;
    box_colour = 24'hFF00FF;
    while (p != 30) begin
      step_next(hv, ev);
      if (hv) begin
        total++;
        if (obs !== ev) begin bad++; $display("FAIL pre_reset: got=%h exp=%h", obs, ev); end
      end
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({vout1.vid_data, vout1.vid_hsync, vout1.vid_vsync, vout1.vid_VDE, fcnt1} !== '0) begin
      bad++; $display("FAIL async_reset_dut1: got=%h exp=0", {vout1.vid_data, vout1.vid_VDE, fcnt1});
    end
    total++;
    if ({vout2.vid_data, vout2.vid_hsync, vout2.vid_vsync, vout2.vid_VDE, fcnt2} !== '0) begin
      bad++; $display("FAIL async_reset_dut2: got=%h exp=0", {vout2.vid_data, vout2.vid_VDE, fcnt2});
    end
    @(posedge clk);
    #2 rst = 1'b0;
    sb.delete();
    model_reset();
    hits1 = 0;
    while (p != 0) begin
      step_next(hv, ev);
      if (hv) begin
        total++;
        if (obs !== ev) begin bad++; $display("FAIL post_reset_partial: got=%h exp=%h", obs, ev); end
      end
    end
    total++;
    if (hits1 !== 0) begin bad++; $display("FAIL post_reset_partial_hits: got=%0d exp=0", hits1); end
    hits1 = 0;
    repeat (FLEN) begin
      step_next(hv, ev);
      if (hv) begin
        total++;
        if (obs !== ev) begin bad++; $display("FAIL post_reset_frame: got=%h exp=%h", obs, ev); end
      end
    end
    total++;
    if (hits1 !== 16) begin bad++; $display("FAIL post_reset_hits: got=%0d exp=16", hits1); end
    total++;
    if (fcnt1 !== CW'(1)) begin bad++; $display("FAIL post_reset_frame_cnt: got=%0d exp=1", fcnt1); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_outline();
    test_shadowing();
    test_degenerate();
    test_blink();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
